// File: rtl/vid_addr_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : vid_addr_cnt
//  Description : Video fetch address counter. Reloads from the base on frame,
//                advances per display fetch, adds a line offset at end of line.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_addr_cnt #(
    parameter int ADDR_W = 21,
    parameter int OFF_W  = 8
) (
    input  logic              i_clk32,
    input  logic              i_porb,
    input  logic              i_frame,
    input  logic [ADDR_W-1:0] i_vbase,
    input  logic              i_de,
    input  logic              i_fetch,
    input  logic [OFF_W-1:0]  i_hoff,
    input  logic [2:0]        i_wloc_we,
    input  logic [7:0]        i_wdata,
    output logic [ADDR_W-1:0] o_vid,
    output logic              o_line_end,
    output logic              o_wrapped
);

    localparam int c_SUM_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_LINE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_de_q;
    logic [ADDR_W-1:0]   r_vid;
    logic                r_line_end;
    logic                r_wrapped;

    logic                w_de_rise;
    logic                w_de_fall;
    logic [c_SUM_W-1:0]  w_sum;
    logic [ADDR_W-1:0]   w_vid_wr;
    logic [ADDR_W-1:0]   w_vid_nxt;
    logic                w_line_end_nxt;
    logic                w_wrapped_nxt;

    assign w_de_rise = i_de & ~r_de_q;
    assign w_de_fall = ~i_de & r_de_q;

    // One extra bit on the sum catches the carry out of the top of the address.
    assign w_sum = {1'b0, r_vid}
                 + c_SUM_W'(i_fetch)
                 + (w_de_fall ? c_SUM_W'(i_hoff) : c_SUM_W'(0));

    always_comb begin
        w_vid_wr = r_vid;
        if (i_wloc_we[0]) w_vid_wr[6:0]         = i_wdata[7:1];
        if (i_wloc_we[1]) w_vid_wr[14:7]        = i_wdata;
        if (i_wloc_we[2]) w_vid_wr[ADDR_W-1:15] = i_wdata[ADDR_W-16:0];
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_vid_nxt      = r_vid;
        w_line_end_nxt = 1'b0;
        w_wrapped_nxt  = r_wrapped;

        case (r_state)
            S_IDLE:  w_state_nxt = S_IDLE;
            S_GAP:   if (w_de_rise) w_state_nxt = S_LINE;
            S_LINE:  if (w_de_fall) w_state_nxt = S_GAP;
            default: w_state_nxt = S_IDLE;
        endcase

        if (i_frame) begin
            w_state_nxt   = S_GAP;
            w_vid_nxt     = i_vbase;
            w_wrapped_nxt = 1'b0;
        end else if (|i_wloc_we) begin
            w_vid_nxt = w_vid_wr;
        end else if (r_state == S_LINE) begin
            w_vid_nxt      = w_sum[ADDR_W-1:0];
            w_line_end_nxt = w_de_fall;
            if (w_sum[ADDR_W]) w_wrapped_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk32 or negedge i_porb) begin
        if (!i_porb) begin
            r_state    <= S_IDLE;
            r_de_q     <= 1'b0;
            r_vid      <= '0;
            r_line_end <= 1'b0;
            r_wrapped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_de_q     <= i_de;
            r_vid      <= w_vid_nxt;
            r_line_end <= w_line_end_nxt;
            r_wrapped  <= w_wrapped_nxt;
        end
    end

    assign o_vid      = r_vid;
    assign o_line_end = r_line_end;
    assign o_wrapped  = r_wrapped;

endmodule
`default_nettype wire
